// File: rtl/gpio_pkg.sv
// gpio_pkg
// Shared constants for the GPIO pad controller slice.
//   NPIN_DEF    : default number of pads in a bank
//   CW_DEF      : default width of the debounce cycle counter
//   SYNC_STAGES : flops in the pad readback synchronizer
package gpio_pkg;

    localparam int NPIN_DEF    = 8;
    localparam int CW_DEF      = 16;
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/gpio_pin_filter.sv
// gpio_pin_filter
// Input side of a single pad: synchronizer, debounce filter, edge pulses and
// sticky edge-interrupt pending flag.
// Ports:
//   clk_i, rstn_i   clock, asynchronous active-low reset
//   pad_o_i         asynchronous pad readback
//   deb_cycles_i    debounce length in cycles (0 = no filtering)
//   irq_rise_en_i   capture rise pulses into the pending flag
//   irq_fall_en_i   capture fall pulses into the pending flag
//   irq_clr_i       write-1-to-clear of the pending flag
//   in_val_o        filtered level
//   rise_o, fall_o  one-cycle pulses on filtered edges
//   irq_pend_o      sticky pending flag
module gpio_pin_filter
    import gpio_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          pad_o_i,
    input  logic [CW-1:0] deb_cycles_i,
    input  logic          irq_rise_en_i,
    input  logic          irq_fall_en_i,
    input  logic          irq_clr_i,
    output logic          in_val_o,
    output logic          rise_o,
    output logic          fall_o,
    output logic          irq_pend_o
);

    logic [SYNC_STAGES-1:0] sync_p;
    logic                   sync_lvl;
    logic [CW-1:0]          cnt;
    logic                   differs;
    logic                   accept;
    logic                   irq_set;

    // Counter stops at all-ones so a very long deb_cycles_i never wraps back
    // below the threshold.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        sat_inc = (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign sync_lvl = sync_p[SYNC_STAGES-1];
    assign differs  = (sync_lvl != in_val_o);
    // >= rather than == so lowering the threshold mid-count takes effect on
    // the very next cycle.
    assign accept   = differs && (cnt >= deb_cycles_i);
    assign irq_set  = (rise_o & irq_rise_en_i) | (fall_o & irq_fall_en_i);

    // Stage: synchronizer
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], pad_o_i};
        end
    end

    // Stage: debounce, filtered level and edge pulses
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt      <= '0;
            in_val_o <= 1'b0;
            rise_o   <= 1'b0;
            fall_o   <= 1'b0;
        end else begin
            rise_o <= accept &  sync_lvl;
            fall_o <= accept & ~sync_lvl;
            if (!differs) begin
                cnt <= '0;
            end else if (accept) begin
                in_val_o <= sync_lvl;
                cnt      <= '0;
            end else begin
                cnt <= sat_inc(cnt);
            end
        end
    end

    // Stage: interrupt pending (set beats clear)
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            irq_pend_o <= 1'b0;
        end else if (irq_set) begin
            irq_pend_o <= 1'b1;
        end else if (irq_clr_i) begin
            irq_pend_o <= 1'b0;
        end
    end

endmodule

// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl
// Core-side controller for a bank of bidirectional pads. Drives the tristate
// buffer I/T inputs (push-pull or open-drain per pin) and filters the pad
// readback into levels, edge pulses and a maskable sticky interrupt.
// Ports:
//   clk_i, rstn_i                 clock, asynchronous active-low reset
//   out_val_i, out_en_i           requested output level / enable per pin
//   od_mode_i                     1 = open-drain, 0 = push-pull
//   pad_i_o, pad_t_o              pad buffer I and T (1 = high-Z), registered
//   pad_o_i                       asynchronous pad readback
//   deb_cycles_i                  debounce length (0 = no filtering)
//   in_val_o, rise_o, fall_o      filtered level and edge pulses
//   irq_rise_en_i, irq_fall_en_i  edge interrupt enables
//   irq_clr_i                     write-1-to-clear of pending flags
//   irq_pend_o, irq_o             pending flags and their OR
module gpio_pad_ctrl
    import gpio_pkg::*;
#(
    parameter int NPIN = NPIN_DEF,
    parameter int CW   = CW_DEF
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic [NPIN-1:0] out_val_i,
    input  logic [NPIN-1:0] out_en_i,
    input  logic [NPIN-1:0] od_mode_i,
    output logic [NPIN-1:0] pad_i_o,
    output logic [NPIN-1:0] pad_t_o,
    input  logic [NPIN-1:0] pad_o_i,
    input  logic [CW-1:0]   deb_cycles_i,
    output logic [NPIN-1:0] in_val_o,
    output logic [NPIN-1:0] rise_o,
    output logic [NPIN-1:0] fall_o,
    input  logic [NPIN-1:0] irq_rise_en_i,
    input  logic [NPIN-1:0] irq_fall_en_i,
    input  logic [NPIN-1:0] irq_clr_i,
    output logic [NPIN-1:0] irq_pend_o,
    output logic            irq_o
);

    logic [NPIN-1:0] pad_i_nxt;
    logic [NPIN-1:0] pad_t_nxt;

    // Open-drain pins never drive high: I is held at 0 and only T toggles.
    always_comb begin
        pad_i_nxt = out_val_i & ~od_mode_i;
        pad_t_nxt = (~od_mode_i & ~out_en_i) |
                    ( od_mode_i & ~(out_en_i & ~out_val_i));
    end

    // Stage: output register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pad_i_o <= '0;
            pad_t_o <= '1;
        end else begin
            pad_i_o <= pad_i_nxt;
            pad_t_o <= pad_t_nxt;
        end
    end

    for (genvar g = 0; g < NPIN; g++) begin : g_pin
        gpio_pin_filter #(.CW(CW)) u_filt (
            .clk_i         (clk_i),
            .rstn_i        (rstn_i),
            .pad_o_i       (pad_o_i[g]),
            .deb_cycles_i  (deb_cycles_i),
            .irq_rise_en_i (irq_rise_en_i[g]),
            .irq_fall_en_i (irq_fall_en_i[g]),
            .irq_clr_i     (irq_clr_i[g]),
            .in_val_o      (in_val_o[g]),
            .rise_o        (rise_o[g]),
            .fall_o        (fall_o[g]),
            .irq_pend_o    (irq_pend_o[g])
        );
    end

    assign irq_o = |irq_pend_o;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
module tb_gpio_pad_ctrl;

    logic        clk_i;
    logic        rstn_i;
    logic [7:0]  out_val_i;
    logic [7:0]  out_en_i;
    logic [7:0]  od_mode_i;
    logic [7:0]  pad_i_o;
    logic [7:0]  pad_t_o;
    logic [7:0]  pad_o_i;
    logic [15:0] deb_cycles_i;
    logic [7:0]  in_val_o;
    logic [7:0]  rise_o;
    logic [7:0]  fall_o;
    logic [7:0]  irq_rise_en_i;
    logic [7:0]  irq_fall_en_i;
    logic [7:0]  irq_clr_i;
    logic [7:0]  irq_pend_o;
    logic        irq_o;

    int n_cmp;
    int n_fail;

    gpio_pad_ctrl #(.NPIN(8), .CW(16)) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .out_val_i     (out_val_i),
        .out_en_i      (out_en_i),
        .od_mode_i     (od_mode_i),
        .pad_i_o       (pad_i_o),
        .pad_t_o       (pad_t_o),
        .pad_o_i       (pad_o_i),
        .deb_cycles_i  (deb_cycles_i),
        .in_val_o      (in_val_o),
        .rise_o        (rise_o),
        .fall_o        (fall_o),
        .irq_rise_en_i (irq_rise_en_i),
        .irq_fall_en_i (irq_fall_en_i),
        .irq_clr_i     (irq_clr_i),
        .irq_pend_o    (irq_pend_o),
        .irq_o         (irq_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance n clock edges, landing 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0; pad_o_i = 8'hFF; deb_cycles_i = 16'd0;
        out_val_i = 8'h00; out_en_i = 8'h00; od_mode_i = 8'h00;
        irq_rise_en_i = 8'h00; irq_fall_en_i = 8'h00; irq_clr_i = 8'h00;
        step(3);
        n_cmp++; if (pad_t_o !== 8'hFF) begin n_fail++; $display("FAIL rst_pad_t got %h want ff", pad_t_o); end
        n_cmp++; if (pad_i_o !== 8'h00) begin n_fail++; $display("FAIL rst_pad_i got %h want 00", pad_i_o); end
        n_cmp++; if (in_val_o !== 8'h00) begin n_fail++; $display("FAIL rst_in_val got %h want 00", in_val_o); end
        n_cmp++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL rst_irq got %b want 0", irq_o); end
        rstn_i = 1'b1;
        step(2);
        n_cmp++; if (rise_o !== 8'h00) begin n_fail++; $display("FAIL rst_early_rise got %h want 00", rise_o); end
        step(1);
        n_cmp++; if (rise_o !== 8'hFF) begin n_fail++; $display("FAIL rst_rise got %h want ff", rise_o); end
        n_cmp++; if (in_val_o !== 8'hFF) begin n_fail++; $display("FAIL rst_in_val_up got %h want ff", in_val_o); end
        step(1);
        n_cmp++; if (rise_o !== 8'h00) begin n_fail++; $display("FAIL rst_rise_end got %h want 00", rise_o); end
    endtask

    task automatic test_output_modes();
        out_en_i = 8'hFF; out_val_i = 8'hFF; od_mode_i = 8'h00;
        step(1);
        n_cmp++; if (pad_t_o !== 8'h00) begin n_fail++; $display("FAIL pp_t got %h want 00", pad_t_o); end
        n_cmp++; if (pad_i_o !== 8'hFF) begin n_fail++; $display("FAIL pp_i got %h want ff", pad_i_o); end
        od_mode_i = 8'hFF;
        step(1);
        n_cmp++; if (pad_t_o !== 8'hFF) begin n_fail++; $display("FAIL od_hi_t got %h want ff", pad_t_o); end
        n_cmp++; if (pad_i_o !== 8'h00) begin n_fail++; $display("FAIL od_hi_i got %h want 00", pad_i_o); end
        out_val_i = 8'h00;
        step(1);
        n_cmp++; if (pad_t_o !== 8'h00) begin n_fail++; $display("FAIL od_lo_t got %h want 00", pad_t_o); end
        n_cmp++; if (pad_i_o !== 8'h00) begin n_fail++; $display("FAIL od_lo_i got %h want 00", pad_i_o); end
        // Mixed: low nibble open-drain, high nibble push-pull.
        od_mode_i = 8'h0F; out_val_i = 8'hA5; out_en_i = 8'h3C;
        #2;
        n_cmp++; if (pad_t_o !== 8'h00) begin n_fail++; $display("FAIL mix_hold_t got %h want 00", pad_t_o); end
        step(1);
        n_cmp++; if (pad_t_o !== 8'hC7) begin n_fail++; $display("FAIL mix_t got %h want c7", pad_t_o); end
        n_cmp++; if (pad_i_o !== 8'hA0) begin n_fail++; $display("FAIL mix_i got %h want a0", pad_i_o); end
        out_en_i = 8'h00; out_val_i = 8'h00; od_mode_i = 8'h00;
    endtask

    task automatic test_debounce();
        int bad;
        deb_cycles_i = 16'd4;
        pad_o_i = 8'h00;
        step(6);
        n_cmp++; if (in_val_o !== 8'hFF) begin n_fail++; $display("FAIL deb_fall_early got %h want ff", in_val_o); end
        step(1);
        n_cmp++; if (in_val_o !== 8'h00 || fall_o !== 8'hFF) begin n_fail++; $display("FAIL deb_fall in_val %h fall %h want 00 ff", in_val_o, fall_o); end
        step(1);
        pad_o_i = 8'h01;
        step(6);
        n_cmp++; if (in_val_o !== 8'h00 || rise_o !== 8'h00) begin n_fail++; $display("FAIL deb_rise_early in_val %h rise %h want 00 00", in_val_o, rise_o); end
        step(1);
        n_cmp++; if (in_val_o !== 8'h01 || rise_o !== 8'h01) begin n_fail++; $display("FAIL deb_rise in_val %h rise %h want 01 01", in_val_o, rise_o); end
        step(1);
        n_cmp++; if (rise_o !== 8'h00 || in_val_o !== 8'h01) begin n_fail++; $display("FAIL deb_rise_once rise %h in_val %h want 00 01", rise_o, in_val_o); end
        // 4-cycle glitch on pin1 must be swallowed with deb_cycles_i = 4.
        bad = 0;
        pad_o_i = 8'h03;
        step(4);
        pad_o_i = 8'h01;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (in_val_o !== 8'h01 || rise_o !== 8'h00 || fall_o !== 8'h00) bad++;
        end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL deb_glitch bad_cycles %0d want 0 (in_val %h)", bad, in_val_o); end
    endtask

    task automatic test_threshold_change();
        deb_cycles_i = 16'hFFFF;
        pad_o_i = 8'h00;
        step(30);
        n_cmp++; if (in_val_o !== 8'h01) begin n_fail++; $display("FAIL sat_hold got %h want 01", in_val_o); end
        deb_cycles_i = 16'd2;
        step(1);
        n_cmp++; if (in_val_o !== 8'h00 || fall_o !== 8'h01) begin n_fail++; $display("FAIL thr_drop in_val %h fall %h want 00 01", in_val_o, fall_o); end
        step(1);
        n_cmp++; if (fall_o !== 8'h00) begin n_fail++; $display("FAIL thr_fall_once got %h want 00", fall_o); end
    endtask

    task automatic test_irq();
        deb_cycles_i = 16'd0;
        irq_fall_en_i = 8'h08; irq_rise_en_i = 8'h00;
        pad_o_i = 8'h08;
        step(3);
        n_cmp++; if (rise_o !== 8'h08) begin n_fail++; $display("FAIL irq_rise_pulse got %h want 08", rise_o); end
        step(1);
        n_cmp++; if (irq_pend_o !== 8'h00 || irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_rise_masked pend %h irq %b want 00 0", irq_pend_o, irq_o); end
        irq_rise_en_i = 8'h08;
        step(1);
        n_cmp++; if (irq_pend_o !== 8'h00) begin n_fail++; $display("FAIL irq_late_en got %h want 00", irq_pend_o); end
        irq_rise_en_i = 8'h00;
        pad_o_i = 8'h00;
        step(3);
        n_cmp++; if (fall_o !== 8'h08) begin n_fail++; $display("FAIL irq_fall_pulse got %h want 08", fall_o); end
        step(1);
        n_cmp++; if (irq_pend_o !== 8'h08 || irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_fall_set pend %h irq %b want 08 1", irq_pend_o, irq_o); end
        step(2);
        n_cmp++; if (irq_pend_o !== 8'h08) begin n_fail++; $display("FAIL irq_sticky got %h want 08", irq_pend_o); end
        irq_clr_i = 8'h08;
        step(1);
        irq_clr_i = 8'h00;
        n_cmp++; if (irq_pend_o !== 8'h00 || irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_clr pend %h irq %b want 00 0", irq_pend_o, irq_o); end
        pad_o_i = 8'h08;
        step(5);
        pad_o_i = 8'h00;
        step(3);
        irq_clr_i = 8'h08;
        step(1);
        irq_clr_i = 8'h00;
        n_cmp++; if (irq_pend_o !== 8'h08) begin n_fail++; $display("FAIL irq_set_wins got %h want 08", irq_pend_o); end
    endtask

    task automatic test_async_reset();
        deb_cycles_i = 16'd4;
        out_en_i = 8'hFF; out_val_i = 8'hFF;
        pad_o_i = 8'h01;
        step(4);
        n_cmp++; if (pad_t_o !== 8'h00) begin n_fail++; $display("FAIL ar_pre_t got %h want 00", pad_t_o); end
        rstn_i = 1'b0;
        #1;
        n_cmp++; if (irq_pend_o !== 8'h00 || irq_o !== 1'b0 || pad_t_o !== 8'hFF || pad_i_o !== 8'h00) begin
            n_fail++; $display("FAIL ar_async pend %h irq %b t %h i %h want 00 0 ff 00", irq_pend_o, irq_o, pad_t_o, pad_i_o);
        end
        step(2);
        rstn_i = 1'b1;
        out_en_i = 8'h00; out_val_i = 8'h00;
        step(6);
        n_cmp++; if (in_val_o !== 8'h00 || rise_o !== 8'h00) begin n_fail++; $display("FAIL ar_restart_early in_val %h rise %h want 00 00", in_val_o, rise_o); end
        step(1);
        n_cmp++; if (in_val_o !== 8'h01 || rise_o !== 8'h01) begin n_fail++; $display("FAIL ar_restart in_val %h rise %h want 01 01", in_val_o, rise_o); end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        test_output_modes();
        test_debounce();
        test_threshold_change();
        test_irq();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
